alu_core: RTL and testbench

- RV32I integer ALU in the execute stage.
- Combinationally computes one of 11 operations on two XLEN-bit operands and raises a zero flag.
- Also provides a one-cycle registered copy of the result and flag, for pipeline-register use downstream.
- Combinational outputs have zero latency; registered outputs follow one clk later.

---
 rtl/alu_core_pkg.sv | 27 ++
 rtl/alu_core_if.sv | 23 ++
 rtl/alu_core_shifter.sv | 22 ++
 rtl/alu_core.sv | 71 +++++++
 tb/tb_alu_core.sv | 138 +++++++++++++
 5 files changed

// File: rtl/alu_core_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width and opcode encodings.
package alu_core_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_XOR    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_AND    = 4'd4,
    ALU_LSL    = 4'd5,
    ALU_LSR    = 4'd6,
    ALU_ASR    = 4'd7,
    ALU_LT     = 4'd8,
    ALU_LTU    = 4'd9,
    ALU_PASS_1 = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu_core_if.sv
// Operand/opcode/result bundle between the issue logic and the ALU.
interface alu_core_if;
  import alu_core_pkg::*;

  logic [XLEN-1:0] in_0;
  logic [XLEN-1:0] in_1;
  logic [3:0]      operation;
  logic [XLEN-1:0] out;
  logic            zero;
  logic [XLEN-1:0] out_q;
  logic            zero_q;

  modport master (
    output in_0, in_1, operation,
    input  out, zero, out_q, zero_q
  );

  modport slave (
    input  in_0, in_1, operation,
    output out, zero, out_q, zero_q
  );

endinterface

// File: rtl/alu_core_shifter.sv
// Barrel shifter for LSL/LSR/ASR; only the low SHAMT_W bits of the amount reach this block.
module alu_core_shifter
  import alu_core_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_e        mode,
  output logic [XLEN-1:0]    result
);

  // Shift selection; unused mode encoding yields zero rather than X
  always_comb begin
    result = {XLEN{1'b0}};
    case (mode)
      SH_LSL:  result = data << shamt;
      SH_LSR:  result = data >> shamt;
      SH_ASR:  result = $unsigned($signed(data) >>> shamt);
      default: result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// RV32I execute-stage ALU: combinational result/zero plus a one-cycle registered copy.
module alu_core
  import alu_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_core_if.slave  bus
);

  shift_mode_e     shift_mode_s;
  logic [XLEN-1:0] shift_result_s;
  logic [XLEN-1:0] result_s;
  logic            zero_s;
  logic [XLEN-1:0] out_q_r;
  logic            zero_q_r;

  // Shifter mode decode
  always_comb begin
    shift_mode_s = SH_LSL;
    case (bus.operation)
      ALU_LSR: shift_mode_s = SH_LSR;
      ALU_ASR: shift_mode_s = SH_ASR;
      default: shift_mode_s = SH_LSL;
    endcase
  end

  alu_core_shifter u_shifter (
    .data   (bus.in_0),
    .shamt  (bus.in_1[SHAMT_W-1:0]),
    .mode   (shift_mode_s),
    .result (shift_result_s)
  );

  // Operation select; reserved opcodes produce zero so no X escapes
  always_comb begin
    result_s = {XLEN{1'b0}};
    case (bus.operation)
      ALU_ADD:    result_s = bus.in_0 + bus.in_1;
      ALU_SUB:    result_s = bus.in_0 - bus.in_1;
      ALU_XOR:    result_s = bus.in_0 ^ bus.in_1;
      ALU_OR:     result_s = bus.in_0 | bus.in_1;
      ALU_AND:    result_s = bus.in_0 & bus.in_1;
      ALU_LSL,
      ALU_LSR,
      ALU_ASR:    result_s = shift_result_s;
      ALU_LT:     result_s = {{(XLEN-1){1'b0}}, ($signed(bus.in_0) < $signed(bus.in_1))};
      ALU_LTU:    result_s = {{(XLEN-1){1'b0}}, (bus.in_0 < bus.in_1)};
      ALU_PASS_1: result_s = bus.in_1;
      default:    result_s = {XLEN{1'b0}};
    endcase
  end

  assign zero_s   = (result_s == {XLEN{1'b0}});
  assign bus.out  = result_s;
  assign bus.zero = zero_s;

  // Pipeline copy of result and flag; reset state mirrors a zero result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_r  <= {XLEN{1'b0}};
      zero_q_r <= 1'b1;
    end else begin
      out_q_r  <= result_s;
      zero_q_r <= zero_s;
    end
  end

  assign bus.out_q  = out_q_r;
  assign bus.zero_q = zero_q_r;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: every opcode, reserved codes and register/reset timing.
module tb_alu_core;
  import alu_core_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_core_if bus ();

  alu_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    bus.operation = op;
    bus.in_0      = a;
    bus.in_1      = b;
    #1;
    check_val({tag, "_out"}, bus.out, exp);
    check_val({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.operation = 4'd0;
    bus.in_0      = 32'd0;
    bus.in_1      = 32'd0;

    // Registers: async assert between edges, release, capture, mid-stream reset
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_out_q", bus.out_q, 32'd0);
    check_val("rst_async_zero_q", {31'd0, bus.zero_q}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.operation = 4'd0;
    bus.in_0      = 32'd5;
    bus.in_1      = 32'd7;
    #1;
    check_val("pre_edge_out_q", bus.out_q, 32'd0);
    check_val("pre_edge_zero_q", {31'd0, bus.zero_q}, 32'd1);
    check_val("pre_edge_out", bus.out, 32'd12);
    @(posedge clk);
    #1;
    check_val("post_edge_out_q", bus.out_q, 32'd12);
    check_val("post_edge_zero_q", {31'd0, bus.zero_q}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_q", bus.out_q, 32'd0);
    check_val("mid_rst_zero_q", {31'd0, bus.zero_q}, 32'd1);
    check_val("mid_rst_out", bus.out, 32'd12);
    @(posedge clk);
    #1;
    check_val("rst_hold_out_q", bus.out_q, 32'd0);
    rst = 1'b0;

    // Arithmetic
    apply("add_5_7",   4'd0, 32'd5,          32'd7,          32'd12);
    apply("add_m2_7",  4'd0, 32'hFFFF_FFFE,  32'd7,          32'd5);
    apply("add_wrap",  4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0);
    apply("sub_5_7",   4'd1, 32'd5,          32'd7,          32'hFFFF_FFFE);
    apply("sub_m2_m7", 4'd1, 32'hFFFF_FFFE,  32'hFFFF_FFF9,  32'd5);
    apply("sub_15_0",  4'd1, 32'd15,         32'd0,          32'd15);
    apply("sub_4_4",   4'd1, 32'd4,          32'd4,          32'd0);

    // Logic and pass-through
    apply("xor_5_6",   4'd2, 32'd5,          32'd6,          32'd3);
    apply("xor_10_3",  4'd2, 32'd10,         32'd3,          32'd9);
    apply("or_10_3",   4'd3, 32'd10,         32'd3,          32'd11);
    apply("or_11_m11", 4'd3, 32'd11,         32'hFFFF_FFF5,  32'hFFFF_FFFF);
    apply("and_10_3",  4'd4, 32'd10,         32'd3,          32'd2);
    apply("pass_8_14", 4'd10, 32'd8,         32'd14,         32'd14);

    // Shifts, including shift-amount masking
    apply("lsl_5_3",   4'd5, 32'd5,          32'd3,          32'd40);
    apply("lsl_1_37",  4'd5, 32'd1,          32'd37,         32'd32);
    apply("lsl_31",    4'd5, 32'h8000_0001,  32'd31,         32'h8000_0000);
    apply("lsr_10_3",  4'd6, 32'd10,         32'd3,          32'd1);
    apply("lsr_m1_3",  4'd6, 32'hFFFF_FFFF,  32'd3,          32'h1FFF_FFFF);
    apply("asr_10_3",  4'd7, 32'd10,         32'd3,          32'd1);
    apply("asr_m10_3", 4'd7, 32'hFFFF_FFF6,  32'd3,          32'hFFFF_FFFE);
    apply("asr_m1_37", 4'd7, 32'hFFFF_FFFF,  32'd37,         32'hFFFF_FFFF);
    apply("asr_min_4", 4'd7, 32'h8000_0000,  32'd4,          32'hF800_0000);

    // Compares
    apply("lt_10_3",   4'd8, 32'd10,         32'd3,          32'd0);
    apply("lt_2_5",    4'd8, 32'd2,          32'd5,          32'd1);
    apply("lt_m10_3",  4'd8, 32'hFFFF_FFF6,  32'd3,          32'd1);
    apply("lt_m2_m3",  4'd8, 32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd0);
    apply("ltu_10_3",  4'd9, 32'd10,         32'd3,          32'd0);
    apply("ltu_2_5",   4'd9, 32'd2,          32'd5,          32'd1);
    apply("ltu_m10_3", 4'd9, 32'hFFFF_FFF6,  32'd3,          32'd0);
    apply("ltu_5_m3",  4'd9, 32'd5,          32'hFFFF_FFFD,  32'd1);
    apply("ltu_m2_m3", 4'd9, 32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd0);

    // Reserved opcodes
    for (int op = 11; op < 16; op++) begin
      apply($sformatf("rsvd_%0d", op), op[3:0], 32'hDEAD_BEEF, 32'h1234_5678, 32'd0);
    end

    // Register follows a non-zero then a zero result
    apply("reg_src_or", 4'd3, 32'h00F0_0000, 32'h0000_000F, 32'h00F0_000F);
    @(posedge clk);
    #1;
    check_val("reg_or_out_q", bus.out_q, 32'h00F0_000F);
    check_val("reg_or_zero_q", {31'd0, bus.zero_q}, 32'd0);
    apply("reg_src_sub0", 4'd1, 32'd9, 32'd9, 32'd0);
    @(posedge clk);
    #1;
    check_val("reg_sub0_out_q", bus.out_q, 32'd0);
    check_val("reg_sub0_zero_q", {31'd0, bus.zero_q}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
